// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and state type for the 1-to-4 TDM demultiplexer.
//   NUM_CH - number of channels (slots per frame)
//   SLOT_W - width of the slot counter
//   state_t - framing state machine states
package tdm_pkg;
    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_demux_1_to_4_slot_decoder.sv
// slot_decoder: 2-to-4 one-hot decoder with enable.
//   en     in  - when low the output is all zeros
//   sel    in  - slot index to decode
//   onehot out - one-hot slot select, drives strobes and hold-register write enables
module slot_decoder
    import tdm_pkg::*;
(
    input  logic              en,
    input  logic [SLOT_W-1:0] sel,
    output logic [NUM_CH-1:0] onehot
);
    always_comb onehot = en ? NUM_CH'(1) << sel : '0;
endmodule

// File: rtl/tdm_demux_1_to_4.sv
// tdm_demux_1_to_4: receive-side TDM demux, one serial word stream onto four channels.
//   clk, rst_n       in  - clock, asynchronous active-low reset
//   in_valid         in  - accept in_data/in_sof this cycle
//   in_sof           in  - accepted word is slot 0 of a frame
//   in_data          in  - slot word
//   ch_data          out - per-channel hold registers, channel n at [n*WIDTH +: WIDTH]
//   ch_strobe        out - one-hot pulse for the channel written this cycle
//   frame_data       out - snapshot of the last complete frame
//   frame_valid      out - pulse when frame_data updates
//   locked           out - framing state machine is LOCKED
//   sync_err         out - pulse on in_sof outside slot 0 while LOCKED
module tdm_demux_1_to_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]       ch_strobe,
    output logic [NUM_CH*WIDTH-1:0] frame_data,
    output logic                    frame_valid,
    output logic                    locked,
    output logic                    sync_err
);
    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic              complete;
    logic              take;
    logic              err;
    logic              last;
    logic [SLOT_W-1:0] wr_slot;
    logic [NUM_CH-1:0] wr_en;

    // In HUNT only an in_sof word is taken; in LOCKED every valid word is.
    // An in_sof word always lands in slot 0, which also resynchronises after an error.
    assign take    = in_valid && (state == LOCKED || in_sof);
    assign wr_slot = in_sof ? '0 : slot;
    assign err     = in_valid && in_sof && state == LOCKED && slot != '0;
    assign last    = take && wr_slot == SLOT_W'(NUM_CH - 1) && complete;
    assign locked  = state == LOCKED;

    slot_decoder u_dec (
        .en     (take),
        .sel    (wr_slot),
        .onehot (wr_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            complete    <= 1'b0;
            ch_data     <= '0;
            ch_strobe   <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            ch_strobe   <= wr_en;
            sync_err    <= err;
            frame_valid <= last;
            for (int n = 0; n < NUM_CH; n++)
                if (wr_en[n]) ch_data[n*WIDTH +: WIDTH] <= in_data;
            if (last) frame_data <= {in_data, ch_data[(NUM_CH-1)*WIDTH-1:0]};
            if (take) begin
                state <= LOCKED;
                slot  <= wr_slot + 1'b1;
                // Armed by a slot-0 write, consumed by the slot-3 write that completes the frame.
                complete <= wr_slot == '0 ? 1'b1 : wr_slot == SLOT_W'(NUM_CH - 1) ? 1'b0 : complete;
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// tb_tdm_demux_1_to_4: directed and randomized checks against a frame-level model.
module tb_tdm_demux_1_to_4;
    localparam int W = 8;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [4*W-1:0] ch_data;
    logic [3:0]     ch_strobe;
    logic [4*W-1:0] frame_data;
    logic           frame_valid;
    logic           locked;
    logic           sync_err;

    int checks = 0;
    int fails = 0;

    // Model: last word per channel, the words of the frame in progress, last full frame.
    logic [W-1:0]   m_ch[4];
    logic [W-1:0]   cur[$];
    logic [4*W-1:0] m_frame;
    logic [3:0]     m_strobe;
    logic           m_fv;
    logic           m_locked;
    logic           m_err;

    always #5 clk = ~clk;

    tdm_demux_1_to_4 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .ch_data(ch_data), .ch_strobe(ch_strobe), .frame_data(frame_data),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    function automatic logic [4*W-1:0] m_vec();
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        cur.delete();
        m_frame = '0; m_strobe = '0; m_fv = 0; m_locked = 0; m_err = 0;
    endtask

    // Word position within a frame is simply how many words of it have arrived.
    task automatic model_word(input logic v, input logic sof, input logic [W-1:0] d);
        m_strobe = '0; m_fv = 0; m_err = 0;
        if (!v || (!m_locked && !sof)) return;
        if (sof) begin
            m_err = m_locked && cur.size() != 0;
            cur.delete();
        end
        m_locked = 1;
        m_ch[cur.size()] = d;
        m_strobe = 4'(1 << cur.size());
        cur.push_back(d);
        if (cur.size() == 4) begin
            m_frame = {cur[3], cur[2], cur[1], cur[0]};
            m_fv = 1;
            cur.delete();
        end
    endtask

    task automatic step(input logic v, input logic sof, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v; in_sof = sof; in_data = d;
        @(posedge clk);
        #1;
        model_word(v, sof, d);
        in_valid = 0; in_sof = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 8'h5A);
        step(1, 0, 8'h6B);
        do_reset();
        checks++;
        if (ch_data !== '0 || ch_strobe !== '0 || frame_data !== '0 || frame_valid !== 0 ||
            locked !== 0 || sync_err !== 0) begin
            fails++;
            $display("FAIL reset: ch=%h stb=%b fd=%h fv=%b lk=%b err=%b required all 0",
                     ch_data, ch_strobe, frame_data, frame_valid, locked, sync_err);
        end
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_hunt();
        logic [W-1:0] w[2] = '{8'hAA, 8'hBB};
        foreach (w[i]) begin
            step(1, 0, w[i]);
            checks++;
            if (ch_strobe !== 4'b0 || ch_data !== '0 || locked !== 0) begin
                fails++;
                $display("FAIL hunt[%0d]: stb=%b ch=%h lk=%b required 0000/0/0", i, ch_strobe, ch_data, locked);
            end
        end
    endtask

    task automatic test_frame(input int gap);
        logic [W-1:0] w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int fv_cnt = 0;
        foreach (w[i]) begin
            step(1, i == 0, w[i]);
            fv_cnt += int'(frame_valid);
            checks++;
            if (ch_strobe !== 4'(1 << i) || ch_data[i*W +: W] !== w[i] || locked !== 1) begin
                fails++;
                $display("FAIL frame gap%0d slot%0d: stb=%b ch=%h lk=%b required %b/%h/1",
                         gap, i, ch_strobe, ch_data[i*W +: W], locked, 4'(1 << i), w[i]);
            end
            for (int g = 0; g < gap && i < 3; g++) begin
                step(0, 1, 8'hEE);
                checks++;
                if (ch_strobe !== 0 || ch_data !== m_vec() || frame_valid !== 0 || frame_data !== m_frame ||
                    locked !== 1 || sync_err !== 0) begin
                    fails++;
                    $display("FAIL gap slot%0d: stb=%b ch=%h fv=%b fd=%h required 0000/%h/0/%h",
                             i, ch_strobe, ch_data, frame_valid, frame_data, m_vec(), m_frame);
                end
            end
        end
        checks++;
        if (fv_cnt != 1 || frame_data !== 32'h44332211) begin
            fails++;
            $display("FAIL frame gap%0d result: fv_count=%0d fd=%h required 1/44332211", gap, fv_cnt, frame_data);
        end
    endtask

    task automatic test_sync_err();
        logic [4*W-1:0] prev = m_frame;
        step(1, 1, 8'h01);
        step(1, 0, 8'h02);
        step(1, 1, 8'h05);
        checks++;
        if (sync_err !== 1 || ch_strobe !== 4'b0001 || ch_data[W-1:0] !== 8'h05 || locked !== 1) begin
            fails++;
            $display("FAIL sync_err: err=%b stb=%b ch0=%h lk=%b required 1/0001/05/1",
                     sync_err, ch_strobe, ch_data[W-1:0], locked);
        end
        step(1, 0, 8'h06);
        step(1, 0, 8'h07);
        checks++;
        if (frame_valid !== 0 || frame_data !== prev || sync_err !== 0) begin
            fails++;
            $display("FAIL sync_partial: fv=%b fd=%h err=%b required 0/%h/0", frame_valid, frame_data, sync_err, prev);
        end
        step(1, 0, 8'h08);
        checks++;
        if (frame_valid !== 1 || frame_data !== 32'h08070605) begin
            fails++;
            $display("FAIL sync_recover: fv=%b fd=%h required 1/08070605", frame_valid, frame_data);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w[4] = '{8'h66, 8'h77, 8'h88, 8'h99};
        step(1, 1, 8'h21);
        step(1, 0, 8'h22);
        do_reset();
        @(negedge clk) rst_n = 1;
        foreach (w[i]) begin
            step(1, 0, w[i]);
            checks++;
            if (ch_strobe !== 0 || ch_data !== '0 || locked !== 0 || frame_valid !== 0) begin
                fails++;
                $display("FAIL post_reset_ignore[%0d]: stb=%b ch=%h lk=%b fv=%b required 0", i, ch_strobe, ch_data, locked, frame_valid);
            end
        end
        for (int i = 0; i < 4; i++) step(1, i == 0, 8'hA1 + 8'(i));
        checks++;
        if (frame_valid !== 1 || frame_data !== 32'hA4A3A2A1 || locked !== 1) begin
            fails++;
            $display("FAIL post_reset_frame: fv=%b fd=%h lk=%b required 1/a4a3a2a1/1", frame_valid, frame_data, locked);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic v = $urandom_range(0, 3) != 0;
            logic s = $urandom_range(0, 4) == 0;
            step(v, s, W'($urandom));
            checks++;
            if (ch_data !== m_vec() || ch_strobe !== m_strobe || frame_data !== m_frame ||
                frame_valid !== m_fv || locked !== m_locked || sync_err !== m_err) begin
                fails++;
                $display("FAIL random[%0d]: ch=%h stb=%b fd=%h fv=%b lk=%b err=%b required %h/%b/%h/%b/%b/%b",
                         i, ch_data, ch_strobe, frame_data, frame_valid, locked, sync_err,
                         m_vec(), m_strobe, m_frame, m_fv, m_locked, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_hunt();
        test_frame(0);
        test_frame(2);
        test_sync_err();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
